apb_master_bridge: RTL and testbench

Converts the core's req/gnt/rvalid data-port protocol into single APB3 master transfers that drive the peripheral bus node. It issues exactly one APB transfer per granted request, returns read data and the slave error flag on a one-cycle response strobe, and supports back-to-back requests. It sits between the core/AXI-side data path and the APB slave port of the peripheral bus wrapper.

---
 rtl/apb_master_bridge.sv | 134 +++++++++++++
 tb/tb_apb_master_bridge.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// apb_master_bridge
//   Turns the core's req/gnt/rvalid data-port handshake into single APB3
//   master transfers. Each granted request produces one SETUP + ACCESS
//   sequence, and the result comes back on a one-cycle rvalid_o strobe. A
//   request can be granted in the response cycle, so back-to-back transfers
//   take 3 cycles each.
//
//   Optional build macro:
//     APB_MASTER_TIMEOUT_EN - aborts an ACCESS phase that has seen pready_i
//                             low for TIMEOUT_CYCLES cycles. The transfer
//                             answers with err_o=1 and rdata_o=0.
//
//   Ports:
//     clk_i, rst_i           clock, synchronous active-high reset
//     req_i/gnt_o            request valid / accepted (gnt_o combinational)
//     addr_i, we_i, wdata_i  request payload, held with req_i until gnt_o
//     rvalid_o, rdata_o,     response strobe, read data (0 on writes and
//     err_o                  timeouts), slave error
//     paddr_o, pwdata_o,     APB master outputs (all registered)
//     pwrite_o, psel_o,
//     penable_o
//     prdata_i, pready_i,    APB slave response
//     pslverr_i
module apb_master_bridge #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  output logic                      gnt_o,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic                      we_i,
  input  logic [APB_DATA_WIDTH-1:0] wdata_i,
  output logic                      rvalid_o,
  output logic [APB_DATA_WIDTH-1:0] rdata_o,
  output logic                      err_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [APB_DATA_WIDTH-1:0] pwdata_o,
  output logic                      pwrite_o,
  output logic                      psel_o,
  output logic                      penable_o,
  input  logic [APB_DATA_WIDTH-1:0] prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state;

  // Grants only when the bus is free or finishing; never while in reset.
  assign gnt_o = req_i & ~rst_i & ((state == IDLE) | (state == RESP));

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout;

  // wait_cnt counts stalled ACCESS cycles already seen; this cycle is the
  // one that reaches the limit when the incremented count equals it.
  assign timeout = (wait_cnt + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      pwrite_o  <= 1'b0;
      paddr_o   <= '0;
      pwdata_o  <= '0;
      rvalid_o  <= 1'b0;
      rdata_o   <= '0;
      err_o     <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      rvalid_o <= 1'b0;
      case (state)
        // RESP shares IDLE's grant path so a new request overlaps the
        // response strobe; psel_o/penable_o are already low in both.
        IDLE, RESP: begin
          if (gnt_o) begin
            paddr_o   <= addr_i;
            pwrite_o  <= we_i;
            pwdata_o  <= wdata_i;
            psel_o    <= 1'b1;
            penable_o <= 1'b0;
            state     <= SETUP;
          end else begin
            state <= IDLE;
          end
        end
        SETUP: begin
          penable_o <= 1'b1;
          state     <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
          wait_cnt  <= '0;
`endif
        end
        ACCESS: begin
          // pready_i has priority, so a completion in the limit cycle is
          // reported normally rather than as a timeout.
          if (pready_i) begin
            rdata_o   <= pwrite_o ? '0 : prdata_i;
            err_o     <= pslverr_i;
            rvalid_o  <= 1'b1;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            state     <= RESP;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else if (timeout) begin
            rdata_o   <= '0;
            err_o     <= 1'b1;
            rvalid_o  <= 1'b1;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
module tb_apb_master_bridge;

  logic        clk, rst, req, gnt, we, rvalid, err;
  logic [31:0] addr, wdata, rdata, paddr, pwdata, prdata;
  logic        pwrite, psel, penable, pready, pslverr;
  int          n_chk  = 0;
  int          n_fail = 0;

  apb_master_bridge #(
    .APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .addr_i(addr),
    .we_i(we), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata),
    .err_o(err), .paddr_o(paddr), .pwdata_o(pwdata), .pwrite_o(pwrite),
    .psel_o(psel), .penable_o(penable), .prdata_i(prdata),
    .pready_i(pready), .pslverr_i(pslverr)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled on
  // the falling edge of the same cycle.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; req = 1; we = 1; addr = $urandom; wdata = $urandom;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++; if (gnt !== 1'b0) begin n_fail++; $display("FAIL rst_gnt got=%b exp=0", gnt); end
    n_chk++; if ({psel, penable, pwrite, rvalid, err} !== 5'b0) begin n_fail++;
      $display("FAIL rst_ctrl got=%b exp=00000", {psel, penable, pwrite, rvalid, err}); end
    n_chk++; if ({paddr, pwdata, rdata} !== 96'd0) begin n_fail++;
      $display("FAIL rst_data paddr=%h pwdata=%h rdata=%h exp=0", paddr, pwdata, rdata); end
    tick(); rst = 0; req = 0;
  endtask

  task automatic test_read_zero_wait();
    tick(); req = 1; we = 0; addr = 32'h1A10_0004; wdata = $urandom; pready = 0; pslverr = 0;
    @(negedge clk);
    n_chk++; if ({gnt, psel} !== 2'b10) begin n_fail++; $display("FAIL rd_c0 gnt,psel got=%b exp=10", {gnt, psel}); end
    tick(); req = 0; pready = 1; prdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_chk++; if ({psel, penable, rvalid, pwrite} !== 4'b1000 || paddr !== 32'h1A10_0004) begin n_fail++;
      $display("FAIL rd_c1 ctl=%b paddr=%h exp 1000/1a100004", {psel, penable, rvalid, pwrite}, paddr); end
    tick();
    @(negedge clk);
    n_chk++; if ({psel, penable, rvalid} !== 3'b110) begin n_fail++; $display("FAIL rd_c2 got=%b exp=110", {psel, penable, rvalid}); end
    tick(); pready = 0; prdata = $urandom;
    @(negedge clk);
    n_chk++; if ({rvalid, err, psel, penable} !== 4'b1000 || rdata !== 32'hDEAD_BEEF) begin n_fail++;
      $display("FAIL rd_c3 ctl=%b rdata=%h exp 1000/deadbeef", {rvalid, err, psel, penable}, rdata); end
    tick();
    @(negedge clk);
    n_chk++; if (rvalid !== 1'b0 || rdata !== 32'hDEAD_BEEF) begin n_fail++;
      $display("FAIL rd_hold rvalid=%b rdata=%h exp 0/deadbeef", rvalid, rdata); end
  endtask

  task automatic test_write_waits();
    logic [31:0] a;
    a = $urandom;
    tick(); req = 1; we = 1; addr = a; wdata = 32'h0000_00A5; pready = 0;
    @(negedge clk);
    n_chk++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL wr_gnt got=%b exp=1", gnt); end
    tick(); req = 0; addr = $urandom; wdata = $urandom; we = 0;
    for (int k = 0; k < 4; k++) begin
      tick(); pready = (k == 3); pslverr = (k != 3); prdata = $urandom;
      @(negedge clk);
      n_chk++; if ({psel, penable, rvalid, pwrite} !== 4'b1101 || paddr !== a || pwdata !== 32'hA5) begin n_fail++;
        $display("FAIL wr_access%0d ctl=%b paddr=%h pwdata=%h exp 1101/%h/a5", k, {psel, penable, rvalid, pwrite}, paddr, pwdata, a); end
    end
    tick(); pready = 0; pslverr = 0;
    @(negedge clk);
    n_chk++; if ({rvalid, err} !== 2'b10 || rdata !== 32'd0) begin n_fail++;
      $display("FAIL wr_resp rvalid,err=%b rdata=%h exp 10/0", {rvalid, err}, rdata); end
  endtask

  task automatic test_slave_error();
    logic [31:0] d;
    d = $urandom;
    tick(); req = 1; we = 0; addr = $urandom;
    tick(); req = 0; pready = 0; pslverr = 1;
    tick(); pready = 0; pslverr = 1; prdata = $urandom;
    @(negedge clk);
    n_chk++; if ({psel, penable, rvalid} !== 3'b110) begin n_fail++; $display("FAIL err_wait got=%b exp=110", {psel, penable, rvalid}); end
    tick(); pready = 1; pslverr = 1; prdata = d;
    tick(); pready = 0; pslverr = 0; prdata = $urandom;
    @(negedge clk);
    n_chk++; if ({rvalid, err} !== 2'b11 || rdata !== d) begin n_fail++;
      $display("FAIL err_resp rvalid,err=%b rdata=%h exp 11/%h", {rvalid, err}, rdata, d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] av [3];
    logic [31:0] dv [3];
    logic [31:0] pv [3];
    logic        wv [3];
    logic        e_gnt, e_rv;
    for (int j = 0; j < 3; j++) begin
      av[j] = $urandom; dv[j] = $urandom; pv[j] = $urandom; wv[j] = (j == 1);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      req = (k <= 6);
      if (k <= 6) begin addr = av[k / 3]; we = wv[k / 3]; wdata = dv[k / 3]; end
      pready = 1; pslverr = 0;
      prdata = (k % 3 == 2) ? pv[(k - 2) / 3] : $urandom;
      @(negedge clk);
      e_gnt = (k <= 6) && (k % 3 == 0);
      e_rv  = (k >= 3) && (k % 3 == 0);
      n_chk++; if ({gnt, rvalid, psel, penable} !== {e_gnt, e_rv, k % 3 != 0, k % 3 == 2}) begin n_fail++;
        $display("FAIL b2b_c%0d gnt,rv,psel,pen got=%b exp=%b", k, {gnt, rvalid, psel, penable},
                 {e_gnt, e_rv, k % 3 != 0, k % 3 == 2}); end
      if (e_rv) begin
        n_chk++; if (rdata !== (wv[k / 3 - 1] ? 32'd0 : pv[k / 3 - 1])) begin n_fail++;
          $display("FAIL b2b_rdata%0d got=%h exp=%h", k / 3 - 1, rdata, wv[k / 3 - 1] ? 32'd0 : pv[k / 3 - 1]); end
      end
      if (k % 3 != 0) begin
        n_chk++; if (paddr !== av[(k - 1) / 3] || pwrite !== wv[(k - 1) / 3]) begin n_fail++;
          $display("FAIL b2b_paddr_c%0d got=%h exp=%h", k, paddr, av[(k - 1) / 3]); end
      end
    end
    pready = 0;
  endtask

  task automatic test_reset_mid();
    logic ok;
    tick(); req = 1; we = 0; addr = $urandom; pready = 0;
    tick(); req = 0;
    tick();
    tick(); rst = 1; req = 1;
    @(negedge clk);
    n_chk++; if (gnt !== 1'b0) begin n_fail++; $display("FAIL rstmid_gnt got=%b exp=0", gnt); end
    tick(); rst = 0; req = 0; pready = 1;
    @(negedge clk);
    n_chk++; if ({psel, penable, rvalid} !== 3'b000) begin n_fail++; $display("FAIL rstmid_drop got=%b exp=000", {psel, penable, rvalid}); end
    ok = 1;
    repeat (3) begin tick(); @(negedge clk); if (rvalid !== 1'b0 || psel !== 1'b0) ok = 0; end
    n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rstmid_quiet got=%b exp=1", ok); end
    pready = 0;
  endtask

  // Reference model: transfer i granted at cycle g has SETUP at g+1, ACCESS
  // at g+2..g+2+waits, and its response at g+3+waits.
  localparam int N = 24;
  task automatic test_random();
    logic [31:0] ta [N];
    logic [31:0] td [N];
    logic        tw [N];
    int          twt [N];
    int          tg [N];
    logic [31:0] rd;
    logic        e;
    for (int i = 0; i < N; i++) begin
      ta[i] = $urandom; td[i] = $urandom; tw[i] = 1'($urandom_range(0, 1));
      twt[i] = $urandom_range(0, 3); tg[i] = (i == 0) ? 1 : $urandom_range(0, 2);
    end
    rd = '0; e = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (tg[i] != 0) begin
        repeat (tg[i] - 1) begin
          tick(); req = 0;
          @(negedge clk);
          n_chk++; if ({rvalid, psel} !== 2'b00) begin n_fail++; $display("FAIL rnd_idle%0d got=%b exp=00", i, {rvalid, psel}); end
        end
        tick(); req = 1; addr = ta[i]; we = tw[i]; wdata = td[i];
        @(negedge clk);
        n_chk++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL rnd_gnt%0d got=%b exp=1", i, gnt); end
      end
      tick(); req = 0; pready = 0; addr = $urandom; wdata = $urandom;
      @(negedge clk);
      n_chk++; if ({psel, penable, pwrite} !== {2'b10, tw[i]} || paddr !== ta[i] || pwdata !== td[i]) begin n_fail++;
        $display("FAIL rnd_setup%0d ctl=%b paddr=%h pwdata=%h exp %b/%h/%h", i, {psel, penable, pwrite}, paddr, pwdata,
                 {2'b10, tw[i]}, ta[i], td[i]); end
      for (int k = 0; k <= twt[i]; k++) begin
        tick(); pready = (k == twt[i]); prdata = $urandom; pslverr = 1'($urandom_range(0, 1));
        rd = prdata; e = pslverr;
        @(negedge clk);
        n_chk++; if ({psel, penable, rvalid} !== 3'b110) begin n_fail++; $display("FAIL rnd_access%0d got=%b exp=110", i, {psel, penable, rvalid}); end
      end
      tick(); pready = 0; pslverr = 0;
      if (i + 1 < N && tg[i + 1] == 0) begin req = 1; addr = ta[i + 1]; we = tw[i + 1]; wdata = td[i + 1]; end
      @(negedge clk);
      n_chk++; if ({rvalid, err, psel} !== {1'b1, e, 1'b0} || rdata !== (tw[i] ? 32'd0 : rd)) begin n_fail++;
        $display("FAIL rnd_resp%0d rv,err,psel=%b rdata=%h exp %b/%h", i, {rvalid, err, psel}, rdata, {1'b1, e, 1'b0}, tw[i] ? 32'd0 : rd); end
      if (i + 1 < N && tg[i + 1] == 0) begin
        n_chk++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL rnd_b2b_gnt%0d got=%b exp=1", i + 1, gnt); end
      end
    end
    tick(); req = 0;
  endtask

  task automatic test_timeout();
    logic ok;
    tick(); req = 1; we = 0; addr = $urandom; pready = 0; prdata = 32'hCAFE_F00D;
    tick(); req = 0;
    ok = 1;
`ifdef APB_MASTER_TIMEOUT_EN
    for (int k = 0; k < 4; k++) begin
      tick(); @(negedge clk); if ({psel, penable, rvalid} !== 3'b110) ok = 0;
    end
    n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL to_access got=%b exp=1", ok); end
    tick();
    @(negedge clk);
    n_chk++; if ({rvalid, err, psel, penable} !== 4'b1100 || rdata !== 32'd0) begin n_fail++;
      $display("FAIL to_abort ctl=%b rdata=%h exp 1100/0", {rvalid, err, psel, penable}, rdata); end
    tick();
    @(negedge clk);
    n_chk++; if ({rvalid, psel} !== 2'b00) begin n_fail++; $display("FAIL to_after got=%b exp=00", {rvalid, psel}); end
`else
    for (int k = 0; k < 1005; k++) begin
      tick(); @(negedge clk); if ({psel, penable, rvalid} !== 3'b110) ok = 0;
    end
    n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL to_nolimit got=%b exp=1", ok); end
    tick(); rst = 1;
    tick(); rst = 0;
    @(negedge clk);
    n_chk++; if ({psel, penable, rvalid} !== 3'b000) begin n_fail++; $display("FAIL to_recover got=%b exp=000", {psel, penable, rvalid}); end
`endif
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 0; rst = 1; req = 0; we = 0; addr = '0; wdata = '0;
    prdata = '0; pready = 0; pslverr = 0;
    test_reset();
    test_read_zero_wait();
    test_write_waits();
    test_slave_error();
    test_back_to_back();
    test_reset_mid();
    test_read_zero_wait();
    test_random();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
